// File: rtl/ledstring_sched_pkg.sv
// Shared definitions for the LED string frame scheduler: peripheral CSR layout,
// peripheral word addresses, config register indices and sequencer states.
package ledstring_sched_pkg;

    localparam int CSR_STRT   = 31;
    localparam int CSR_BSY    = 30;
    localparam int CSR_LEN_HI = 24;
    localparam int CSR_LEN_LO = 16;
    localparam int LEN_W      = CSR_LEN_HI - CSR_LEN_LO + 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic [9:0] {
        PERIPH_CSR  = 10'h000,
        PERIPH_GLOB = 10'h001
    } periph_addr_e;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_STATUS = 2'd2,
        REG_FCNT   = 2'd3
    } reg_idx_e;

    typedef enum int {
        CTRL_EN     = 0,
        CTRL_TRIG   = 1,
        CTRL_IRQ_EN = 3
    } ctrl_bit_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_KICK = 3'd2,
        ST_POLL = 3'd3,
        ST_DONE = 3'd4
    } sched_state_e;

    // CSR word that starts a refresh of len LEDs.
    function automatic logic [31:0] kick_word(input logic [LEN_W-1:0] len);
        kick_word = '0;
        kick_word[CSR_STRT] = 1'b1;
        kick_word[CSR_LEN_HI:CSR_LEN_LO] = len;
    endfunction

endpackage

// File: rtl/ledstring_arb.sv
// 2:1 round-robin Wishbone arbiter/mux sharing the LED string port between the
// host pass-through and the scheduler sequencer; one idle cycle between transfers.
module ledstring_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_req,
    input  logic [9:0]  h_addr,
    input  logic [31:0] h_wdata,
    input  logic        h_we,
    output logic        h_ack,
    output logic [31:0] h_rdata,
    input  logic        s_req,
    input  logic [9:0]  s_addr,
    input  logic [31:0] s_wdata,
    input  logic        s_we,
    output logic        s_ack,
    output logic [31:0] s_rdata,
    output logic [9:0]  m_addr,
    output logic [31:0] m_wdata,
    output logic        m_we,
    output logic        m_cyc,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    // owner/rr_last encoding: 0 = host, 1 = sched
    logic active_reg, gap_reg, owner_reg, rr_last_reg;
    logic [9:0]  addr_reg;
    logic [31:0] wdata_reg, h_rdata_reg;
    logic        we_reg;
    logic        port_idle, grant_sched;

    always_comb begin
        port_idle = !active_reg && !gap_reg;
        if (h_req && s_req) begin
            grant_sched = !rr_last_reg;
        end else begin
            grant_sched = s_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg  <= 1'b0;
            gap_reg     <= 1'b0;
            owner_reg   <= 1'b0;
            rr_last_reg <= 1'b1;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            h_rdata_reg <= '0;
        end else begin
            gap_reg <= 1'b0;
            if (active_reg) begin
                if (m_ack) begin
                    active_reg <= 1'b0;
                    gap_reg    <= 1'b1;
                    if (!owner_reg) begin
                        h_rdata_reg <= m_rdata;
                    end
                end
            end else if (port_idle && (h_req || s_req)) begin
                active_reg  <= 1'b1;
                owner_reg   <= grant_sched;
                rr_last_reg <= grant_sched;
                addr_reg    <= grant_sched ? s_addr  : h_addr;
                wdata_reg   <= grant_sched ? s_wdata : h_wdata;
                we_reg      <= grant_sched ? s_we    : h_we;
            end
        end
    end

    assign m_cyc   = active_reg;
    assign m_addr  = addr_reg;
    assign m_wdata = wdata_reg;
    assign m_we    = we_reg;
    assign h_ack   = active_reg && m_ack && !owner_reg;
    assign s_ack   = active_reg && m_ack && owner_reg;
    assign h_rdata = h_rdata_reg;
    assign s_rdata = m_rdata;

endmodule

// File: rtl/ledstring_sched.sv
// LED string frame scheduler: config slave, period tick and kick/poll sequencer.
// Optional frame-done interrupt enable bit (CTRL[3]) under macro LEDSCHED_IRQ_EN.
module ledstring_sched
    import ledstring_sched_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    input  logic        c_we,
    input  logic        c_cyc,
    output logic        c_ack,
    input  logic [9:0]  h_addr,
    input  logic [31:0] h_wdata,
    output logic [31:0] h_rdata,
    input  logic        h_we,
    input  logic        h_cyc,
    output logic        h_ack,
    output logic [9:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        m_we,
    output logic        m_cyc,
    input  logic        m_ack,
    output logic        irq
);

    sched_state_e state_reg, state_next;
    logic                en_reg, trig_reg, done_reg, ovr_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [PERIOD_W-1:0] period_reg, tick_cnt_reg;
    logic [CNT_W-1:0]    fcnt_reg;
    logic                c_ack_reg;
    logic [31:0]         c_rdata_reg, rd_word;
    logic                cfg_req, cfg_wr, cfg_rd, tick, busy;
    logic                s_req, s_we, s_ack;
    logic [31:0]         s_rdata;
    logic                unused_bits;
`ifdef LEDSCHED_IRQ_EN
    logic                irq_en_reg;
`endif

    assign cfg_req = c_cyc && !c_ack_reg;
    assign cfg_wr  = cfg_req && c_we;
    assign cfg_rd  = cfg_req && !c_we;
    assign busy    = (state_reg != ST_IDLE) && (state_reg != ST_WAIT);
    assign tick    = en_reg && (period_reg != '0) && (tick_cnt_reg == period_reg - PERIOD_W'(1));

    always_comb begin
        rd_word = '0;
        case (c_addr)
            REG_CTRL: begin
                rd_word[CTRL_EN] = en_reg;
                rd_word[CSR_LEN_HI:CSR_LEN_LO] = len_reg;
`ifdef LEDSCHED_IRQ_EN
                rd_word[CTRL_IRQ_EN] = irq_en_reg;
`endif
            end
            REG_PERIOD: rd_word[PERIOD_W-1:0] = period_reg;
            REG_STATUS: begin
                rd_word[STAT_BUSY] = busy;
                rd_word[STAT_DONE] = done_reg;
                rd_word[STAT_OVR]  = ovr_reg;
            end
            default: rd_word[CNT_W-1:0] = fcnt_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        s_req      = 1'b0;
        s_we       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (trig_reg)    state_next = ST_KICK;
                else if (en_reg) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tick || trig_reg) state_next = ST_KICK;
                else if (!en_reg)     state_next = ST_IDLE;
            end
            ST_KICK: begin
                s_req = 1'b1;
                s_we  = 1'b1;
                if (s_ack) state_next = ST_POLL;
            end
            ST_POLL: begin
                s_req = 1'b1;
                if (s_ack && s_rdata[CSR_STRT:CSR_BSY] == 2'b00) state_next = ST_DONE;
            end
            ST_DONE: state_next = en_reg ? ST_WAIT : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_ack_reg    <= 1'b0;
            c_rdata_reg  <= '0;
            trig_reg     <= 1'b0;
            en_reg       <= 1'b0;
            len_reg      <= '0;
            period_reg   <= '0;
            tick_cnt_reg <= '0;
            done_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
            fcnt_reg     <= '0;
`ifdef LEDSCHED_IRQ_EN
            irq_en_reg   <= 1'b0;
`endif
        end else begin
            c_ack_reg   <= cfg_req;
            c_rdata_reg <= cfg_rd ? rd_word : '0;
            trig_reg    <= cfg_wr && (c_addr == REG_CTRL) && c_wdata[CTRL_TRIG];
            if (cfg_wr && c_addr == REG_CTRL) begin
                en_reg  <= c_wdata[CTRL_EN];
                len_reg <= c_wdata[CSR_LEN_HI:CSR_LEN_LO];
`ifdef LEDSCHED_IRQ_EN
                irq_en_reg <= c_wdata[CTRL_IRQ_EN];
`endif
            end
            if (cfg_wr && c_addr == REG_PERIOD) period_reg <= c_wdata[PERIOD_W-1:0];

            if (!en_reg || tick)        tick_cnt_reg <= '0;
            else if (period_reg != '0)  tick_cnt_reg <= tick_cnt_reg + PERIOD_W'(1);

            // Set wins over a simultaneous write-1-to-clear.
            if (cfg_wr && c_addr == REG_STATUS && c_wdata[STAT_DONE]) done_reg <= 1'b0;
            if (state_reg == ST_DONE) done_reg <= 1'b1;
            if (cfg_wr && c_addr == REG_STATUS && c_wdata[STAT_OVR]) ovr_reg <= 1'b0;
            if (tick && state_reg != ST_WAIT) ovr_reg <= 1'b1;

            if (state_reg == ST_DONE) fcnt_reg <= fcnt_reg + CNT_W'(1);
        end
    end

    ledstring_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .h_req   (h_cyc),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_we    (h_we),
        .h_ack   (h_ack),
        .h_rdata (h_rdata),
        .s_req   (s_req),
        .s_addr  (PERIPH_CSR),
        .s_wdata (kick_word(len_reg)),
        .s_we    (s_we),
        .s_ack   (s_ack),
        .s_rdata (s_rdata),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_we    (m_we),
        .m_cyc   (m_cyc),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    assign c_ack       = c_ack_reg;
    assign c_rdata     = c_rdata_reg;
    assign unused_bits = ^{c_wdata, s_rdata};

`ifdef LEDSCHED_IRQ_EN
    assign irq = done_reg && irq_en_reg;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ledstring_sched.sv
// Directed bench for ledstring_sched with a reactive LED string peripheral model.
module tb_ledstring_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        c_we, c_cyc, c_ack;
    logic [9:0]  h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic        h_we, h_cyc, h_ack;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        m_we, m_cyc, m_ack, irq;

    always #5 clk = ~clk;

    ledstring_sched dut (
        .clk(clk), .rst_n(rst_n),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_we(c_we), .c_cyc(c_cyc), .c_ack(c_ack),
        .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata), .h_we(h_we), .h_cyc(h_cyc), .h_ack(h_ack),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_we(m_we), .m_cyc(m_cyc), .m_ack(m_ack),
        .irq(irq)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int busy_len = 0;

    // Peripheral model: acks one cycle after cyc, stays busy busy_len cycles after a kick.
    int          busy_cnt, cyc_count, kick_cnt, rd_cnt, log_n;
    int          kick_time [0:15];
    logic [31:0] kick_data;
    logic [9:0]  log_addr  [0:1023];
    logic        log_we    [0:1023];
    logic [31:0] log_wdata [0:1023];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack <= 1'b0; m_rdata <= '0; busy_cnt <= 0; cyc_count <= 0;
            kick_cnt <= 0; rd_cnt <= 0; log_n <= 0; kick_data <= '0;
        end else begin
            cyc_count <= cyc_count + 1;
            m_ack <= m_cyc & ~m_ack;
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (m_cyc && !m_ack) begin
                if (log_n < 1024) begin
                    log_addr[log_n]  <= m_addr;
                    log_we[log_n]    <= m_we;
                    log_wdata[log_n] <= m_wdata;
                    log_n <= log_n + 1;
                end
                if (m_we) begin
                    if (m_addr == 10'd0 && m_wdata[31]) begin
                        busy_cnt <= busy_len;
                        if (kick_cnt < 16) kick_time[kick_cnt] <= cyc_count;
                        kick_cnt  <= kick_cnt + 1;
                        kick_data <= m_wdata;
                    end
                end else begin
                    rd_cnt  <= rd_cnt + 1;
                    m_rdata <= (m_addr == 10'd0) ? {1'b0, (busy_cnt != 0), 30'b0}
                                                 : (32'hA500_0000 | {22'b0, m_addr});
                end
            end
        end
    end

    // Master protocol monitor: idle gap after every ack, stable fields during a transfer.
    int          proto_err = 0;
    logic        prev_cyc, prev_ack;
    logic [42:0] prev_fields;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cyc = 1'b0; prev_ack = 1'b0; prev_fields = '0;
        end else begin
            if (prev_ack && m_cyc) proto_err++;
            if (prev_cyc && m_cyc && {m_addr, m_we, m_wdata} != prev_fields) proto_err++;
            prev_cyc = m_cyc; prev_ack = m_ack; prev_fields = {m_addr, m_we, m_wdata};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        c_cyc = 1'b1; c_we = 1'b1; c_addr = a; c_wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!c_ack && n < 4);
        check("cfg_wr_ack", {31'b0, c_ack}, 32'd1);
        c_cyc = 1'b0; c_we = 1'b0;
    endtask

    task automatic cfg_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        int n;
        @(negedge clk);
        c_cyc = 1'b1; c_we = 1'b0; c_addr = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!c_ack && n < 4);
        check(tag, c_rdata, exp);
        c_cyc = 1'b0;
    endtask

    task automatic host_xfer(input logic we, input logic [9:0] a, input logic [31:0] d, output int waited);
        @(negedge clk);
        h_cyc = 1'b1; h_we = we; h_addr = a; h_wdata = d;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!h_ack && waited < 40);
        check("h_ack_seen", {31'b0, h_ack}, 32'd1);
        h_cyc = 1'b0; h_we = 1'b0;
    endtask

    initial begin
        int k0, r0, snap, waited, n;
        rst_n = 1'b0;
        c_addr = '0; c_wdata = '0; c_we = 1'b0; c_cyc = 1'b0;
        h_addr = '0; h_wdata = '0; h_we = 1'b0; h_cyc = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_cyc", {31'b0, m_cyc}, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_c_ack", {31'b0, c_ack}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        cfg_check("rst_status", 2'd2, 32'h0);
        cfg_check("rst_fcnt", 2'd3, 32'h0);

        // One-shot trigger with en=0 (irq enable bit also written)
        busy_len = 5;
        cfg_write(2'd0, 32'h000A_000A);
        repeat (40) @(negedge clk);
        check("oneshot_kicks", kick_cnt, 32'd1);
        check("oneshot_data", kick_data, 32'h800A_0000);
`ifdef LEDSCHED_IRQ_EN
        cfg_check("oneshot_ctrl", 2'd0, 32'h000A_0008);
        check("irq_after_done", {31'b0, irq}, 32'd1);
`else
        cfg_check("oneshot_ctrl", 2'd0, 32'h000A_0000);
        check("irq_after_done", {31'b0, irq}, 32'd0);
`endif
        cfg_check("oneshot_status", 2'd2, 32'h2);
        cfg_check("oneshot_fcnt", 2'd3, 32'd1);
        cfg_write(2'd2, 32'h2);
        cfg_check("done_w1c", 2'd2, 32'h0);
        check("irq_after_w1c", {31'b0, irq}, 32'd0);

        // Periodic frames: PERIOD=1000, bsy for 200 cycles
        busy_len = 200;
        r0 = rd_cnt;
        cfg_write(2'd1, 32'd1000);
        cfg_check("period_rb", 2'd1, 32'd1000);
        cfg_write(2'd0, 32'h000A_0001);
        repeat (3500) @(negedge clk);
        check("periodic_kicks", kick_cnt, 32'd4);
        check("periodic_space1", kick_time[2] - kick_time[1], 32'd1000);
        check("periodic_space2", kick_time[3] - kick_time[2], 32'd1000);
        check("periodic_data", kick_data, 32'h800A_0000);
        check("periodic_polls", {31'b0, (rd_cnt - r0) >= 150}, 32'd1);
        cfg_check("periodic_fcnt", 2'd3, 32'd4);
        cfg_check("periodic_status", 2'd2, 32'h2);
        cfg_write(2'd0, 32'h000A_0000);
        repeat (10) @(negedge clk);

        // Host write colliding with sched KICK, rr_last=sched -> host first
        busy_len = 3;
        snap = log_n;
        cfg_write(2'd0, 32'h000A_0002);
        host_xfer(1'b1, 10'h205, 32'h00FF_00FF, waited);
        check("host_latency", waited, 32'd2);
        repeat (30) @(negedge clk);
        check("arb_first_addr", {22'b0, log_addr[snap]}, 32'h205);
        check("arb_first_data", log_wdata[snap], 32'h00FF_00FF);
        check("arb_second_addr", {21'b0, log_we[snap+1], log_addr[snap+1]}, 32'h400);
        check("arb_second_data", log_wdata[snap+1], 32'h800A_0000);
        check("arb_third_read", {21'b0, log_we[snap+2], log_addr[snap+2]}, 32'h000);
        cfg_check("arb_fcnt", 2'd3, 32'd5);
        host_xfer(1'b0, 10'h123, 32'h0, waited);
        @(negedge clk);
        check("host_rdata", h_rdata, 32'hA500_0123);

        // Overrun: PERIOD=50 while bsy for 120 cycles
        cfg_write(2'd2, 32'h6);
        busy_len = 120;
        k0 = kick_cnt;
        cfg_write(2'd1, 32'd50);
        cfg_write(2'd0, 32'h000A_0001);
        repeat (120) @(negedge clk);
        cfg_check("ovr_busy_status", 2'd2, 32'h5);
        check("ovr_single_kick", kick_cnt - k0, 32'd1);
        cfg_write(2'd0, 32'h000A_0000);
        repeat (100) @(negedge clk);
        check("ovr_kicks_after", kick_cnt - k0, 32'd1);
        cfg_check("ovr_done_status", 2'd2, 32'h6);
        cfg_check("ovr_fcnt", 2'd3, 32'd6);
        cfg_write(2'd2, 32'h4);
        cfg_check("ovr_w1c", 2'd2, 32'h2);

        // Asynchronous reset in the middle of POLL
        busy_len = 100;
        cfg_write(2'd0, 32'h000A_0002);
        repeat (20) @(negedge clk);
        n = 0;
        while (!m_cyc && n < 20) begin @(negedge clk); n++; end
        check("poll_active", {31'b0, m_cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_m_cyc", {31'b0, m_cyc}, 32'd0);
        check("async_m_addr_we", {21'b0, m_we, m_addr}, 32'd0);
        check("async_m_wdata", m_wdata, 32'd0);
        check("async_h_rdata", h_rdata, 32'd0);
        check("async_irq_acks", {29'b0, irq, h_ack, c_ack}, 32'd0);
        check("async_c_rdata", c_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_check("post_rst_status", 2'd2, 32'h0);
        cfg_check("post_rst_fcnt", 2'd3, 32'h0);
        cfg_check("post_rst_period", 2'd1, 32'h0);
        repeat (20) @(negedge clk);
        check("post_rst_no_kick", kick_cnt, 32'd0);
        check("proto_monitor", proto_err, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
